turn_sequencer: RTL and testbench

//   Game controller for the tic-tac-toe datapath: owns the cursor, current player,
//   per-turn countdown, move commit, win/draw resolution and board clear.

---
 rtl/tictactoe_pkg.sv | 32 +++
 rtl/turn_timer.sv | 43 ++++
 rtl/turn_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_turn_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// Shared codes, FSM state type and board helpers for the tic-tac-toe controller.
// Optional feature macro: TURN_AUTOPLAY_EN (adds the S_AUTO random-move state).
package tictactoe_pkg;

  localparam logic [1:0] EMPTY     = 2'b00;
  localparam logic [1:0] P1        = 2'b01;
  localparam logic [1:0] P2        = 2'b10;
  localparam int         NUM_CELLS = 9;

  typedef enum logic [2:0] {
    S_TURN   = 3'd0,
`ifdef TURN_AUTOPLAY_EN
    S_AUTO   = 3'd1,
`endif
    S_COMMIT = 3'd2,
    S_CHECK  = 3'd3,
    S_OVER   = 3'd4,
    S_CLEAR  = 3'd5
  } state_t;

  // Positions 9..15 read as padding so a random source can be probed safely.
  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] pos);
    logic [31:0] padded;
    padded = {14'd0, board};
    return padded[{pos, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: a TICK_DIV prescaler decrementing a saturating tick counter.
// reload has priority over run; expired is high while the counter sits at zero.
module turn_timer #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int TURN_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_reload,
  input  logic       i_run,
  output logic [3:0] o_time_left,
  output logic       o_expired
);

  localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]      RELOAD  = 4'(TURN_TICKS);

  logic [PW-1:0] r_prescaler;
  logic [3:0]    r_time_left;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescaler <= '0;
      r_time_left <= RELOAD;
    end else if (i_reload) begin
      r_prescaler <= '0;
      r_time_left <= RELOAD;
    end else if (i_run) begin
      if (r_prescaler == PRE_MAX) begin
        r_prescaler <= '0;
        if (r_time_left != 4'd0) r_time_left <= r_time_left - 4'd1;
      end else begin
        r_prescaler <= r_prescaler + PW'(1);
      end
    end
  end

  assign o_time_left = r_time_left;
  assign o_expired   = (r_time_left == 4'd0);

endmodule

// File: rtl/turn_sequencer.sv
// Tic-tac-toe game controller: cursor, player turn, countdown, move commit, win/draw, clear.
// Optional feature macro: TURN_AUTOPLAY_EN (timeout places a random move instead of forfeiting).
module turn_sequencer
  import tictactoe_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int TURN_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sel,
  input  logic        i_next,
  input  logic [3:0]  i_rand_pos,
  input  logic [17:0] i_board,
  input  logic [1:0]  i_win,
  output logic        o_wr_en,
  output logic [3:0]  o_wr_pos,
  output logic [1:0]  o_wr_player,
  output logic        o_clr,
  output logic [3:0]  o_cursor,
  output logic [1:0]  o_player,
  output logic [3:0]  o_time_left,
  output logic [1:0]  o_winner,
  output logic        o_draw,
  output logic        o_game_over
);

  state_t     r_state, w_state_next;
  logic       r_sel_q, r_next_q;
  logic [3:0] r_cursor, r_move_cnt, r_wr_pos;
  logic [1:0] r_player, r_wr_player, r_winner;
  logic       r_draw;

  logic       w_sel_e, w_next_e, w_expired;
  logic       w_timer_run, w_timer_reload;
  logic       w_load_wr, w_toggle, w_set_winner, w_set_draw, w_clear_game;
  logic [3:0] w_wr_pos_next;

  assign w_sel_e  = i_sel  & ~r_sel_q;
  assign w_next_e = i_next & ~r_next_q;

  turn_timer #(
    .TICK_DIV   (TICK_DIV),
    .TURN_TICKS (TURN_TICKS)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_reload    (w_timer_reload),
    .i_run       (w_timer_run),
    .o_time_left (o_time_left),
    .o_expired   (w_expired)
  );

`ifndef TURN_AUTOPLAY_EN
  logic w_unused_rand;
  assign w_unused_rand = ^i_rand_pos;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_TURN;
    else     r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    w_state_next   = r_state;
    w_timer_run    = 1'b0;
    w_timer_reload = 1'b0;
    w_load_wr      = 1'b0;
    w_wr_pos_next  = r_cursor;
    w_toggle       = 1'b0;
    w_set_winner   = 1'b0;
    w_set_draw     = 1'b0;
    w_clear_game   = 1'b0;
    o_wr_en        = 1'b0;
    o_clr          = 1'b0;
    o_game_over    = 1'b0;
    case (r_state)
      S_TURN: begin
        w_timer_run = 1'b1;
        // A valid selection beats a timeout landing in the same cycle.
        if (w_sel_e && cell_at(i_board, r_cursor) == EMPTY) begin
          w_load_wr     = 1'b1;
          w_wr_pos_next = r_cursor;
          w_state_next  = S_COMMIT;
        end else if (w_expired) begin
`ifdef TURN_AUTOPLAY_EN
          w_state_next   = S_AUTO;
`else
          w_toggle       = 1'b1;
          w_timer_reload = 1'b1;
`endif
        end
      end
`ifdef TURN_AUTOPLAY_EN
      S_AUTO: begin
        if (i_rand_pos < 4'(NUM_CELLS) && cell_at(i_board, i_rand_pos) == EMPTY) begin
          w_load_wr     = 1'b1;
          w_wr_pos_next = i_rand_pos;
          w_state_next  = S_COMMIT;
        end
      end
`endif
      S_COMMIT: begin
        o_wr_en      = 1'b1;
        w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (i_win != EMPTY) begin
          w_set_winner = 1'b1;
          w_state_next = S_OVER;
        end else if (r_move_cnt == 4'(NUM_CELLS)) begin
          w_set_draw   = 1'b1;
          w_state_next = S_OVER;
        end else begin
          w_toggle       = 1'b1;
          w_timer_reload = 1'b1;
          w_state_next   = S_TURN;
        end
      end
      S_OVER: begin
        o_game_over = 1'b1;
        if (w_sel_e) w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        o_clr          = 1'b1;
        w_clear_game   = 1'b1;
        w_timer_reload = 1'b1;
        w_state_next   = S_TURN;
      end
      default: w_state_next = S_TURN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_q     <= 1'b0;
      r_next_q    <= 1'b0;
      r_cursor    <= '0;
      r_player    <= P1;
      r_move_cnt  <= '0;
      r_wr_pos    <= '0;
      r_wr_player <= P1;
      r_winner    <= EMPTY;
      r_draw      <= 1'b0;
    end else begin
      r_sel_q  <= i_sel;
      r_next_q <= i_next;

      if (w_clear_game) begin
        r_cursor <= '0;
      end else if (w_next_e && r_state != S_OVER) begin
        r_cursor <= (r_cursor == 4'(NUM_CELLS - 1)) ? 4'd0 : r_cursor + 4'd1;
      end

      if (w_clear_game)  r_player <= P1;
      else if (w_toggle) r_player <= other_player(r_player);

      if (w_clear_game)              r_move_cnt <= '0;
      else if (r_state == S_COMMIT)  r_move_cnt <= r_move_cnt + 4'd1;

      if (w_load_wr) begin
        r_wr_pos    <= w_wr_pos_next;
        r_wr_player <= r_player;
      end

      if (w_clear_game)      r_winner <= EMPTY;
      else if (w_set_winner) r_winner <= i_win;

      if (w_clear_game)    r_draw <= 1'b0;
      else if (w_set_draw) r_draw <= 1'b1;
    end
  end

  assign o_wr_pos    = r_wr_pos;
  assign o_wr_player = r_wr_player;
  assign o_cursor    = r_cursor;
  assign o_player    = r_player;
  assign o_winner    = r_winner;
  assign o_draw      = r_draw;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: grid/win model, write scoreboard, timing-exact moves.
// Optional feature macro: TURN_AUTOPLAY_EN selects the autoplay timeout scenario.
module tb_turn_sequencer;
  import tictactoe_pkg::*;

  localparam int TICK_DIV   = 4;
  localparam int TURN_TICKS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_sel = 1'b0;
  logic        i_next = 1'b0;
  logic [3:0]  i_rand_pos = 4'd0;
  logic [17:0] board;
  logic [1:0]  win;
  logic        o_wr_en, o_clr, o_draw, o_game_over;
  logic [3:0]  o_wr_pos, o_cursor, o_time_left;
  logic [1:0]  o_wr_player, o_player, o_winner;

  typedef struct packed {
    logic [3:0] pos;
    logic [1:0] player;
  } wr_t;

  wr_t        exp_q[$];
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         wr_count  = 0;
  int         clr_count = 0;
  logic       force_no_win = 1'b0;
  logic [3:0] tb_cursor = 4'd0;
  logic [1:0] tb_player = P1;

  always #5 clk = ~clk;

  turn_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .TURN_TICKS (TURN_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sel       (i_sel),
    .i_next      (i_next),
    .i_rand_pos  (i_rand_pos),
    .i_board     (board),
    .i_win       (win),
    .o_wr_en     (o_wr_en),
    .o_wr_pos    (o_wr_pos),
    .o_wr_player (o_wr_player),
    .o_clr       (o_clr),
    .o_cursor    (o_cursor),
    .o_player    (o_player),
    .o_time_left (o_time_left),
    .o_winner    (o_winner),
    .o_draw      (o_draw),
    .o_game_over (o_game_over)
  );

  // Grid model: one write port, clear strobe, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          board <= '0;
    else if (o_clr)   board <= '0;
    else if (o_wr_en && o_wr_pos < 4'd9) board[int'(o_wr_pos)*2 +: 2] <= o_wr_player;
  end

  function automatic logic [1:0] line_winner(input logic [17:0] b);
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic [1:0] a, m, c;
    for (int i = 0; i < 8; i++) begin
      a = b[lines[i][0]*2 +: 2];
      m = b[lines[i][1]*2 +: 2];
      c = b[lines[i][2]*2 +: 2];
      if (a != 2'b00 && a == m && a == c) return a;
    end
    return 2'b00;
  endfunction

  assign win = force_no_win ? 2'b00 : line_winner(board);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected move.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", exp_q.size(), 1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_pos", o_wr_pos, e.pos);
          check("wr_player", o_wr_player, e.player);
        end
      end
      if (o_clr) clr_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    i_sel  = 1'b0;
    i_next = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    tb_cursor = 4'd0;
    tb_player = P1;
  endtask

  // Entered on the first cycle of a turn; exits on the next turn's first cycle,
  // or in the S_CHECK cycle when stop_in_check is set.
  task automatic play_move(input logic [3:0] pos, input bit stop_in_check);
    int steps;
    steps = (int'(pos) - int'(tb_cursor) + 9) % 9;
    for (int s = 0; s < steps; s++) begin
      i_next = 1'b1; tick();
      i_next = 1'b0; tick();
    end
    tb_cursor = pos;
    check("cursor_before_sel", o_cursor, pos);
    exp_q.push_back(wr_t'{pos: pos, player: tb_player});
    i_sel = 1'b1; tick();
    i_sel = 1'b0; tick();
    if (!stop_in_check) begin
      tick();
      tb_player = other_player(tb_player);
    end
  endtask

  task automatic restart_from_over();
    i_sel = 1'b1; tick();
    check("clr_pulse", o_clr, 1);
    i_sel = 1'b0; tick();
    check("clr_done", o_clr, 0);
    check("clear_player", o_player, P1);
    check("clear_cursor", o_cursor, 0);
    check("clear_winner", o_winner, 0);
    check("clear_draw", o_draw, 0);
    check("clear_game_over", o_game_over, 0);
    check("clear_time_left", o_time_left, TURN_TICKS);
    tb_cursor = 4'd0;
    tb_player = P1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, o_wr_en, 0);
    check({tag, "_wr_pos"}, o_wr_pos, 0);
    check({tag, "_wr_player"}, o_wr_player, P1);
    check({tag, "_clr"}, o_clr, 0);
    check({tag, "_cursor"}, o_cursor, 0);
    check({tag, "_player"}, o_player, P1);
    check({tag, "_time_left"}, o_time_left, TURN_TICKS);
    check({tag, "_winner"}, o_winner, 0);
    check({tag, "_draw"}, o_draw, 0);
    check({tag, "_game_over"}, o_game_over, 0);
  endtask

  initial begin
    int wr_before, clr_before, cnt;
    logic [3:0] win_order [5] = '{4'd2, 4'd3, 4'd0, 4'd4, 4'd1};

    do_reset();
    check_reset_outputs("reset");

    // Three cursor steps then a commit on empty cell 3.
    play_move(4'd3, 1'b0);
    check("move1_player", o_player, P2);
    check("move1_writes", wr_count, 1);

    // Select on the occupied cell: ignored while the timer keeps counting.
    i_sel = 1'b1; tick();
    i_sel = 1'b0;
    repeat (3) tick();
    check("occupied_time_left", o_time_left, 2);
    check("occupied_player", o_player, P2);
    check("occupied_writes", wr_count, 1);
    check("occupied_game_over", o_game_over, 0);

    // P1 wins on 0,1,2; the longest hops land sel on the timeout cycle.
    do_reset();
    clr_before = clr_count;
    foreach (win_order[i]) begin
      play_move(win_order[i], 1'b0);
      if (i == 3) check("win_not_yet_over", o_game_over, 0);
    end
    check("win_winner", o_winner, P1);
    check("win_game_over", o_game_over, 1);
    check("win_draw", o_draw, 0);
    i_next = 1'b1; tick();
    i_next = 1'b0; tick();
    check("over_cursor_frozen", o_cursor, 1);
    restart_from_over();
    check("clr_count", clr_count - clr_before, 1);

    // Nine moves with the checker held at no-win.
    force_no_win = 1'b1;
    for (int k = 0; k < 9; k++) begin
      play_move(4'(k), 1'b0);
      if (k == 7) check("draw_not_yet_over", o_game_over, 0);
    end
    check("draw_flag", o_draw, 1);
    check("draw_winner", o_winner, 0);
    check("draw_game_over", o_game_over, 1);
    restart_from_over();
    force_no_win = 1'b0;

    // Idle turn until the countdown expires.
    i_rand_pos = 4'd12;
    do_reset();
    wr_before = wr_count;
`ifdef TURN_AUTOPLAY_EN
    repeat (13) tick();
    tick();
    check("auto_reject_invalid", wr_count, wr_before);
    i_rand_pos = 4'd5;
    exp_q.push_back(wr_t'{pos: 4'd5, player: P1});
    repeat (3) tick();
    check("auto_writes", wr_count, wr_before + 1);
    check("auto_player", o_player, P2);
    check("auto_time_left", o_time_left, TURN_TICKS);
`else
    cnt = 0;
    while (o_player != P2 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", cnt, 13);
    check("timeout_time_left", o_time_left, TURN_TICKS);
    check("timeout_no_write", wr_count, wr_before);
    cnt = 0;
    while (o_player != P1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("timeout2_cycles", cnt, 13);
    check("timeout2_no_write", wr_count, wr_before);
`endif

    // Asynchronous reset landing in S_CHECK after a P2 move.
    do_reset();
    play_move(4'd0, 1'b0);
    play_move(4'd1, 1'b1);
    check("pre_rst_player", o_player, P2);
    check("pre_rst_wr_pos", o_wr_pos, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst = 1'b0;
    tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
